// File: rtl/temp_bram_arb.sv
// temp_bram_arb
// Round-robin arbiter that shares one single-port BRAM between a write
// requester and a read requester. It issues at most one grant per cycle and
// drives the BRAM enables, address and write data from registers. It also
// returns read data two cycles after the read grant. A per-address
// "written" bitmap lets reads of never-written locations be flagged as misses.
//
// Parameters
//   DATA_WIDTH  width of write data, read data and BRAM data
//   ADDR_WIDTH  address width; the bitmap has 2**ADDR_WIDTH entries
//
// Ports
//   clk_i, rstn_i        clock, synchronous active-low reset
//   wr_req_i/addr/data   write request; held until wr_gnt_o
//   wr_gnt_o             one-cycle write grant pulse
//   rd_req_i/rd_addr_i   read request; held until rd_gnt_o
//   rd_gnt_o             one-cycle read grant pulse
//   rd_valid_o           one-cycle pulse qualifying rd_data_o / rd_miss_o
//   rd_data_o            read data, held between valid pulses
//   rd_miss_o            read hit an address with its written flag clear
//   clear_i              clears every written flag at the next edge
//   wr_temp_en_o         BRAM write enable
//   rd_temp_en_o         BRAM read enable
//   temp_addr_o          BRAM address, holds when idle
//   bram_din_o           BRAM write data, holds when idle
//   bram_dout_i          BRAM read data, registered by the BRAM
module temp_bram_arb #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_gnt_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_miss_o,
  input  logic                  clear_i,
  output logic                  wr_temp_en_o,
  output logic                  rd_temp_en_o,
  output logic [ADDR_WIDTH-1:0] temp_addr_o,
  output logic [DATA_WIDTH-1:0] bram_din_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Round-robin pointer: which requester wins when both are eligible.
  typedef enum logic {
    FAV_WR = 1'b0,
    FAV_RD = 1'b1
  } fav_t;

  fav_t             fav_q, fav_d;
  logic [DEPTH-1:0] flags_q, flags_d;

  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;

  // Read pipeline bookkeeping.
  // miss_gnt: miss status of the read currently showing rd_gnt_o.
  // rd_s1/miss_s1: the read whose data the BRAM presents this cycle.
  logic miss_gnt;
  logic rd_s1;
  logic miss_s1;

  // ------------------------------------------------------------------
  // Arbitration and bitmap next-state
  // ------------------------------------------------------------------
  always_comb begin
    wr_elig  = 1'b0;
    rd_elig  = 1'b0;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    fav_d    = fav_q;
    flags_d  = flags_q;

    // A request that is being granted this cycle is not eligible again,
    // so a requester holding req through its grant pulse is not re-granted.
    wr_elig  = wr_req_i & ~wr_gnt_o;
    rd_elig  = rd_req_i & ~rd_gnt_o;

    grant_wr = wr_elig & (~rd_elig | (fav_q == FAV_WR));
    grant_rd = rd_elig & ~grant_wr;

    if (grant_wr) begin
      fav_d = FAV_RD;
    end else if (grant_rd) begin
      fav_d = FAV_WR;
    end

    // Clear first so a coincident write grant still leaves its flag set.
    if (clear_i) begin
      flags_d = '0;
    end
    if (grant_wr) begin
      flags_d[wr_addr_i] = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Registered grants, BRAM side and read return path
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fav_q        <= FAV_WR;
      flags_q      <= '0;
      wr_gnt_o     <= 1'b0;
      rd_gnt_o     <= 1'b0;
      wr_temp_en_o <= 1'b0;
      rd_temp_en_o <= 1'b0;
      temp_addr_o  <= '0;
      bram_din_o   <= '0;
      miss_gnt     <= 1'b0;
      rd_s1        <= 1'b0;
      miss_s1      <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
      rd_miss_o    <= 1'b0;
    end else begin
      fav_q        <= fav_d;
      flags_q      <= flags_d;
      wr_gnt_o     <= grant_wr;
      rd_gnt_o     <= grant_rd;
      wr_temp_en_o <= grant_wr;
      rd_temp_en_o <= grant_rd;

      if (grant_wr) begin
        temp_addr_o <= wr_addr_i;
        bram_din_o  <= wr_data_i;
      end else if (grant_rd) begin
        temp_addr_o <= rd_addr_i;
      end

      // The flag is sampled before this edge's update; a write granted at
      // an earlier edge has already set it.
      if (grant_rd) begin
        miss_gnt <= ~flags_q[rd_addr_i];
      end

      // BRAM samples rd_temp_en_o at the end of the grant cycle and presents
      // data during the following cycle; capture it at the end of that cycle.
      rd_s1 <= rd_gnt_o;
      if (rd_gnt_o) begin
        miss_s1 <= miss_gnt;
      end

      rd_valid_o <= rd_s1;
      if (rd_s1) begin
        rd_data_o <= bram_dout_i;
        rd_miss_o <= miss_s1;
      end
    end
  end

endmodule

// File: tb/tb_temp_bram_arb.sv
// Testbench for temp_bram_arb: directed vector table, hand-written
// reset/alternation sequences, and a randomized run against a
// transaction-level reference model. A small BRAM stub closes the loop.
module tb_temp_bram_arb;

  localparam int DW    = 64;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_miss;
  logic          clear;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] taddr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  always #5 clk = ~clk;

  temp_bram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_gnt_o     (wr_gnt),
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
    .rd_gnt_o     (rd_gnt),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .rd_miss_o    (rd_miss),
    .clear_i      (clear),
    .wr_temp_en_o (wr_en),
    .rd_temp_en_o (rd_en),
    .temp_addr_o  (taddr),
    .bram_din_o   (bram_din),
    .bram_dout_i  (bram_dout)
  );

  // BRAM stub: registered read, 0 when not reading; wipe zeroes contents.
  logic          bram_wipe;
  logic [DW-1:0] bram_mem [DEPTH];

  always @(posedge clk) begin
    if (bram_wipe) begin
      for (int i = 0; i < DEPTH; i++) bram_mem[i] <= '0;
    end else if (wr_en) begin
      bram_mem[taddr] <= bram_din;
    end
    if (rd_en) bram_dout <= bram_mem[taddr];
    else       bram_dout <= '0;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic idle_inputs();
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_addr = '0;
    clear   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_gnt"},   64'(wr_gnt),   64'd0);
    chk({tag, "_rd_gnt"},   64'(rd_gnt),   64'd0);
    chk({tag, "_wr_en"},    64'(wr_en),    64'd0);
    chk({tag, "_rd_en"},    64'(rd_en),    64'd0);
    chk({tag, "_addr"},     64'(taddr),    64'd0);
    chk({tag, "_din"},      bram_din,      64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_data"},  rd_data,       64'd0);
    chk({tag, "_rd_miss"},  64'(rd_miss),  64'd0);
  endtask

  // Leaves the bench at a falling edge with rstn just released.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn      = 1'b0;
    bram_wipe = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    bram_wipe = 1'b0;
    chk_all_zero(tag);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic          wr_req;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rd_req;
    logic [AW-1:0] ra;
    logic          clr;
    logic          e_wg;
    logic          e_rg;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_valid;
    logic [DW-1:0] e_rdata;
    logic          e_miss;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic r, input logic [AW-1:0] ra, input logic clr,
                              input logic eg, input logic erg, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed, input logic ev, input logic [DW-1:0] er,
                              input logic em);
    vec_t v;
    v.wr_req = w;  v.wa = wa; v.wd = wd;
    v.rd_req = r;  v.ra = ra; v.clr = clr;
    v.e_wg = eg;   v.e_rg = erg; v.e_addr = ea; v.e_din = ed;
    v.e_valid = ev; v.e_rdata = er; v.e_miss = em;
    return v;
  endfunction

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        miss;
  } rd_exp_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [21];
    rd_exp_t q [$];
    logic [DW-1:0] mem_m [DEPTH];
    logic          written [DEPTH];
    logic          pref_wr;
    logic          e_wg, e_rg, e_valid, e_miss;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rdata;
    logic          w_act, r_act, clr_r;
    logic [AW-1:0] wa_r, ra_r;
    logic [DW-1:0] wd_r;
    logic          wel, rel, gw, gr;
    rd_exp_t       ent;

    rstn      = 1'b0;
    bram_wipe = 1'b0;
    idle_inputs();

    // ---------------- directed table ----------------
    //              wr wa  wd      rd ra clr | wg rg addr din   v  rdata   miss
    tbl[0]  = mk(1, 3, 64'hAA, 0, 0, 0,  0, 0, 0, 64'h0,  0, 64'h0,  0);
    tbl[1]  = mk(0, 0, 64'h0,  1, 3, 0,  1, 0, 3, 64'hAA, 0, 64'h0,  0);
    tbl[2]  = mk(0, 0, 64'h0,  0, 0, 0,  0, 1, 3, 64'hAA, 0, 64'h0,  0);
    tbl[3]  = mk(0, 0, 64'h0,  0, 0, 0,  0, 0, 3, 64'hAA, 0, 64'h0,  0);
    tbl[4]  = mk(0, 0, 64'h0,  1, 5, 0,  0, 0, 3, 64'hAA, 1, 64'hAA, 0);
    tbl[5]  = mk(0, 0, 64'h0,  0, 0, 0,  0, 1, 5, 64'hAA, 0, 64'hAA, 0);
    tbl[6]  = mk(0, 0, 64'h0,  0, 0, 0,  0, 0, 5, 64'hAA, 0, 64'hAA, 0);
    tbl[7]  = mk(1, 7, 64'h55, 0, 0, 0,  0, 0, 5, 64'hAA, 1, 64'h0,  1);
    tbl[8]  = mk(0, 0, 64'h0,  1, 7, 0,  1, 0, 7, 64'h55, 0, 64'h0,  0);
    tbl[9]  = mk(0, 0, 64'h0,  0, 0, 0,  0, 1, 7, 64'h55, 0, 64'h0,  0);
    tbl[10] = mk(0, 0, 64'h0,  0, 0, 0,  0, 0, 7, 64'h55, 0, 64'h0,  0);
    tbl[11] = mk(1, 2, 64'h12, 0, 0, 0,  0, 0, 7, 64'h55, 1, 64'h55, 0);
    tbl[12] = mk(0, 0, 64'h0,  0, 0, 1,  1, 0, 2, 64'h12, 0, 64'h55, 0);
    tbl[13] = mk(0, 0, 64'h0,  1, 2, 0,  0, 0, 2, 64'h12, 0, 64'h55, 0);
    tbl[14] = mk(0, 0, 64'h0,  0, 0, 0,  0, 1, 2, 64'h12, 0, 64'h55, 0);
    tbl[15] = mk(0, 0, 64'h0,  0, 0, 0,  0, 0, 2, 64'h12, 0, 64'h55, 0);
    tbl[16] = mk(1, 1, 64'h31, 1, 1, 0,  0, 0, 2, 64'h12, 1, 64'h12, 1);
    tbl[17] = mk(0, 0, 64'h0,  1, 1, 0,  1, 0, 1, 64'h31, 0, 64'h12, 0);
    tbl[18] = mk(0, 0, 64'h0,  0, 0, 0,  0, 1, 1, 64'h31, 0, 64'h12, 0);
    tbl[19] = mk(0, 0, 64'h0,  0, 0, 0,  0, 0, 1, 64'h31, 0, 64'h12, 0);
    tbl[20] = mk(0, 0, 64'h0,  0, 0, 0,  0, 0, 1, 64'h31, 1, 64'h31, 0);

    do_reset("rst0");
    for (int k = 0; k < 21; k++) begin
      chk($sformatf("tbl%0d_wr_gnt", k),   64'(wr_gnt),   64'(tbl[k].e_wg));
      chk($sformatf("tbl%0d_rd_gnt", k),   64'(rd_gnt),   64'(tbl[k].e_rg));
      chk($sformatf("tbl%0d_wr_en", k),    64'(wr_en),    64'(tbl[k].e_wg));
      chk($sformatf("tbl%0d_rd_en", k),    64'(rd_en),    64'(tbl[k].e_rg));
      chk($sformatf("tbl%0d_addr", k),     64'(taddr),    64'(tbl[k].e_addr));
      chk($sformatf("tbl%0d_din", k),      bram_din,      tbl[k].e_din);
      chk($sformatf("tbl%0d_rd_valid", k), 64'(rd_valid), 64'(tbl[k].e_valid));
      chk($sformatf("tbl%0d_rd_data", k),  rd_data,       tbl[k].e_rdata);
      if (tbl[k].e_valid)
        chk($sformatf("tbl%0d_rd_miss", k), 64'(rd_miss), 64'(tbl[k].e_miss));
      wr_req  = tbl[k].wr_req;
      wr_addr = tbl[k].wa;
      wr_data = tbl[k].wd;
      rd_req  = tbl[k].rd_req;
      rd_addr = tbl[k].ra;
      clear   = tbl[k].clr;
      @(negedge clk);
    end

    // ---------------- reset while a read is in flight ----------------
    rd_req  = 1'b1;
    rd_addr = 3'd4;
    @(negedge clk);
    chk("inflight_rd_gnt", 64'(rd_gnt), 64'd1);
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("inflight_rst");
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("inflight_no_valid%0d", i), 64'(rd_valid), 64'd0);
    end

    // ---------------- both requesting continuously from reset ----------------
    do_reset("rst1");
    wr_req  = 1'b1;
    wr_addr = 3'd4;
    wr_data = 64'hC0DE;
    rd_req  = 1'b1;
    rd_addr = 3'd6;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("alt%0d_wr_gnt", i), 64'(wr_gnt), 64'((i % 2) == 0));
      chk($sformatf("alt%0d_rd_gnt", i), 64'(rd_gnt), 64'((i % 2) == 1));
      chk($sformatf("alt%0d_excl", i),   64'(wr_en & rd_en), 64'd0);
    end

    // ---------------- randomized run against reference model ----------------
    do_reset("rst2");
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      written[i] = 1'b0;
    end
    pref_wr = 1'b1;
    e_wg = 0; e_rg = 0; e_valid = 0; e_miss = 0;
    e_addr = '0; e_din = '0; e_rdata = '0;
    w_act = 0; r_act = 0;
    wa_r = '0; ra_r = '0; wd_r = '0;

    for (int n = 0; n < 1500; n++) begin
      chk("rnd_wr_gnt",   64'(wr_gnt),   64'(e_wg));
      chk("rnd_rd_gnt",   64'(rd_gnt),   64'(e_rg));
      chk("rnd_wr_en",    64'(wr_en),    64'(e_wg));
      chk("rnd_rd_en",    64'(rd_en),    64'(e_rg));
      chk("rnd_addr",     64'(taddr),    64'(e_addr));
      chk("rnd_din",      bram_din,      e_din);
      chk("rnd_rd_valid", 64'(rd_valid), 64'(e_valid));
      chk("rnd_rd_data",  rd_data,       e_rdata);
      if (e_valid) chk("rnd_rd_miss", 64'(rd_miss), 64'(e_miss));

      // Requesters: drop on grant, then maybe start a new request.
      if (w_act && e_wg) w_act = 1'b0;
      if (r_act && e_rg) r_act = 1'b0;
      if (!w_act && $urandom_range(0, 99) < 55) begin
        w_act = 1'b1;
        wa_r  = AW'($urandom_range(0, DEPTH - 1));
        wd_r  = {$urandom, $urandom};
      end
      if (!r_act && $urandom_range(0, 99) < 55) begin
        r_act = 1'b1;
        ra_r  = AW'($urandom_range(0, DEPTH - 1));
      end
      clr_r = ($urandom_range(0, 99) < 6);

      wr_req  = w_act;
      wr_addr = wa_r;
      wr_data = wd_r;
      rd_req  = r_act;
      rd_addr = ra_r;
      clear   = clr_r;

      // Reference: who wins this edge, and what that means for memory/flags.
      wel = w_act && !e_wg;
      rel = r_act && !e_rg;
      gw  = wel && (!rel || pref_wr);
      gr  = rel && !gw;

      if (gr) begin
        ent.due  = n + 3;
        ent.data = mem_m[ra_r];
        ent.miss = !written[ra_r];
        q.push_back(ent);
        pref_wr = 1'b1;
      end
      if (clr_r) for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
      if (gw) begin
        written[wa_r] = 1'b1;
        mem_m[wa_r]   = wd_r;
        pref_wr       = 1'b0;
      end

      e_wg = gw;
      e_rg = gr;
      if (gw)      begin e_addr = wa_r; e_din = wd_r; end
      else if (gr) e_addr = ra_r;

      e_valid = 1'b0;
      if (q.size() > 0 && q[0].due == n + 1) begin
        ent     = q.pop_front();
        e_valid = 1'b1;
        e_rdata = ent.data;
        e_miss  = ent.miss;
      end

      @(negedge clk);
    end

    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/temp_bram_arb.md
TEMP_BRAM_ARB -- requirements
Module: temp_bram_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data width of the write data, read data and BRAM data ports.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the address width; depth SHALL be 2^ADDR_WIDTH.
REQ-003 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rstn_i  input  1  reset; synchronous, active-low.
REQ-005 wr_req_i  input  1  write requester: request; held high with address and data stable until wr_gnt_o.
REQ-006 wr_addr_i  input  ADDR_WIDTH  write address.
REQ-007 wr_data_i  input  DATA_WIDTH  write data.
REQ-008 wr_gnt_o  output  1  write grant; one-cycle pulse.
REQ-009 rd_req_i  input  1  read requester: request; held high with address stable until rd_gnt_o.
REQ-010 rd_addr_i  input  ADDR_WIDTH  read address.
REQ-011 rd_gnt_o  output  1  read grant; one-cycle pulse.
REQ-012 rd_valid_o  output  1  read data valid; one-cycle pulse.
REQ-013 rd_data_o  output  DATA_WIDTH  read data, qualified by rd_valid_o.
REQ-014 rd_miss_o  output  1  read targeted a never-written address; qualified by rd_valid_o.
REQ-015 clear_i  input  1  clears all written flags.
REQ-016 wr_temp_en_o  output  1  BRAM write enable.
REQ-017 rd_temp_en_o  output  1  BRAM read enable.
REQ-018 temp_addr_o  output  ADDR_WIDTH  BRAM address.
REQ-019 bram_din_o  output  DATA_WIDTH  BRAM write data.
REQ-020 bram_dout_i  input  DATA_WIDTH  BRAM read data; the BRAM registers it one edge after it samples rd_temp_en_o, and drives 0 when not reading.

Function
REQ-021 Eligibility: a requester SHALL be eligible at an edge only if its req is high and its gnt_o is low at that edge. A request held during its own grant cycle SHALL therefore not be re-granted.
REQ-022 At most one grant SHALL be issued per cycle. All grant and BRAM-side outputs SHALL be registered.
REQ-023 Single eligible requester: at edge E it SHALL be granted. In the cycle after E:
 - gnt_o = 1.
 - The matching BRAM enable = 1.
 - temp_addr_o = the sampled address.
 - For writes, bram_din_o = the sampled data.
REQ-024 Both eligible: grant SHALL go to the requester other than the last one granted (round-robin pointer). The pointer SHALL update on every grant; its reset value SHALL favour write.
REQ-025 wr_temp_en_o and rd_temp_en_o SHALL never be high in the same cycle; both SHALL be 0 in cycles with no grant. bram_din_o and temp_addr_o SHALL hold their last value when idle.
REQ-026 Read latency: a read granted in cycle C SHALL produce, in cycle C+2:
 - rd_valid_o = 1.
 - rd_data_o = bram_dout_i as captured at the edge ending C+1.
REQ-027 rd_data_o SHALL hold its value between valid pulses. Back-to-back reads SHALL pipeline, with no drop.
REQ-028 Written flags: a 2^ADDR_WIDTH bitmap.
 - A flag SHALL be set at the edge that issues a write grant to that address.
 - rd_miss_o SHALL equal the flag of the read address as sampled at read-grant issue.
 - A write granted the cycle before a read to the same address SHALL already count as written.
REQ-029 clear_i SHALL zero all flags at the next edge. If clear_i and a write grant coincide, the granted address's flag SHALL end at 1.
REQ-030 Grant order SHALL be preserved at the BRAM. A read granted one cycle after a write to the same address SHALL return the new data.

Reset
REQ-031 While rstn_i is low at an edge, the block SHALL set:
 - All outputs to 0, including rd_data_o.
 - All written flags to 0.
 - The pointer to favour write.
 - All in-flight reads discarded; no rd_valid_o SHALL follow release of reset for reads granted before it.
REQ-032 Requests SHALL be ignored in any cycle where rstn_i is low.

Verification
REQ-033 wr_req_i=1, wr_addr_i=3, wr_data_i=0xAA, held until grant. Expected response:
 - wr_gnt_o and wr_temp_en_o pulse one cycle later with temp_addr_o=3 and bram_din_o=0xAA.
 - A later read of address 3 yields rd_valid_o two cycles after rd_gnt_o, with rd_data_o=0xAA and rd_miss_o=0.
REQ-034 After reset, read address 5 with no prior write -> rd_valid_o with rd_data_o=0 and rd_miss_o=1.
REQ-035 wr_req_i and rd_req_i held high continuously from reset. Expected response:
 - Grants alternate W,R,W,R, starting with W.
 - There is never a simultaneous BRAM enable.
 - Each requester receives one grant per 2 cycles.
REQ-036 Write address 2, then clear_i pulse, then read address 2 -> rd_miss_o=1 and rd_data_o equals the stored BRAM data.
REQ-037 Read granted, then rstn_i low for one cycle before rd_valid_o -> no rd_valid_o; all outputs are 0 the cycle after the reset edge.
REQ-038 Write address 7=0x55 and read address 7 requested in consecutive cycles -> write granted first and rd_data_o=0x55.
